set_assoc_cache_ctrl: RTL and testbench
=======================================

SET_ASSOC_CACHE_CTRL -- requirements
Module: set_assoc_cache_ctrl

Interface
REQ-001 Parameter ADR_W, 16, address width (CPU and memory).
REQ-002 Parameter DATA_W, 8, word width.
REQ-003 Parameter WAYS, 4, associativity; power of 2, 1..8.
REQ-004 Parameter SET_BITS, 3, log2(sets); TAG_W = ADR_W-SET_BITS-OFF_BITS.
REQ-005 Parameter OFF_BITS, 2, log2(words per block).
REQ-006 CLK  in  1  single clock; all logic on rising edge.
REQ-007 RST  in  1  synchronous, active-high reset.
REQ-008 readCPU / writeCPU  in  1 each  CPU read/write request.
REQ-009 adrCPU  in  ADR_W  CPU address {tag,set,offset}.
REQ-010 dataCPUin  in  DATA_W  CPU write data; dataCPUout  out  DATA_W  read data, registered.
REQ-011 stallCPU  out  1  controller busy; doneCPU  out  1  one-cycle completion pulse.
REQ-012 adrMM  out  ADR_W  memory word address; dataMMout  out  DATA_W  write-back data; dataMMin  in  DATA_W  refill data.
REQ-013 readMem / writeMem  out  1 each  memory request; readyMem  in  1  memory transfer-complete strobe.

Function
REQ-014 States SHALL be IDLE, LOOKUP, WRITEBACK, REFILL, UPDATE; stallCPU = (state != IDLE).
REQ-015 In IDLE, readCPU|writeCPU SHALL latch address, data and op, go to LOOKUP; readCPU wins if both high; requests outside IDLE ignored.
REQ-016 LOOKUP SHALL compare latched tag against all WAYS ways of the indexed set in one cycle; hit = valid & tag match.
REQ-017 Read hit: dataCPUout = addressed word, doneCPU=1, state IDLE, at accept cycle T+2.
REQ-018 Write hit: addressed word <= latched data, line dirty=1, doneCPU at T+2.
REQ-019 Replacement: per-way age counters (log2(WAYS) bits) per set; accessed way age -> 0, ways younger than its old age increment; ages stay a permutation.
REQ-020 Victim on miss: lowest-index invalid way, else way with age WAYS-1.
REQ-021 Miss with dirty valid victim -> WRITEBACK; otherwise -> REFILL.
REQ-022 WRITEBACK: words offset 0..2^OFF_BITS-1 at adrMM={victimTag,set,offset}, writeMem=1 with dataMMout held until readyMem, one word per strobe; then REFILL.
REQ-023 REFILL: readMem=1, adrMM={reqTag,set,offset} offset 0 upward; dataMMin captured on readyMem cycle; after last word -> UPDATE.
REQ-024 Memory handshake: request and adrMM stable until readyMem; request deasserted for at least one cycle between words; readyMem ignored when no request.
REQ-025 UPDATE: install tag, valid=1, dirty=0, update ages, then service request as hit (write sets dirty); doneCPU same cycle, state IDLE.
REQ-026 Write-allocate, write-back policy; memory never written on write hit.
REQ-027 WAYS=1 SHALL degenerate to direct-mapped with no age state.

Reset
REQ-028 RST SHALL, at next edge, force IDLE and readMem=writeMem=stallCPU=doneCPU=0, adrMM=dataMMout=dataCPUout=0.
REQ-029 RST SHALL clear all valid and dirty bits, set age of way i to i; data array contents unspecified.
REQ-030 RST mid-WRITEBACK/REFILL SHALL abort the transfer; no partial line becomes valid.

Verification (defaults; 0x1234 -> tag 0x091, set 5, offset 0)
REQ-031 After RST, read 0x1234, memory returns 0xA0..0xA3 -> readMem at adrMM 0x1234..0x1237, no writeMem, doneCPU with dataCPUout=0xA0.
REQ-032 Then read 0x1236 -> hit, doneCPU at T+2, dataCPUout=0xA2, readMem never asserted.
REQ-033 Write 0x1235=0x5C, read 0x1235 -> 0x5C; no memory traffic.
REQ-034 Read 0x0014, 0x0034, 0x0054, then 0x0074 -> victim is 0x1234 line: writeMem to 0x1234..0x1237 with 0xA0,0x5C,0xA2,0xA3, then refill 0x0074..0x0077.
REQ-035 readyMem withheld 20 cycles during REFILL -> readMem, adrMM stable, stallCPU=1 throughout; readCPU and writeCPU high in the same IDLE cycle -> read serviced.
REQ-036 RST during REFILL word 2 -> next cycle readMem=0, stallCPU=0; subsequent read 0x1234 misses.

Source files
------------

// File: rtl/set_assoc_cache_ctrl.sv
// Set-associative, write-back / write-allocate cache controller with age-based LRU
// replacement and a one-word-per-strobe memory handshake.
module set_assoc_cache_ctrl #(
  parameter int ADR_W    = 16,
  parameter int DATA_W   = 8,
  parameter int WAYS     = 4,
  parameter int SET_BITS = 3,
  parameter int OFF_BITS = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              readCPU,
  input  logic              writeCPU,
  input  logic [ADR_W-1:0]  adrCPU,
  input  logic [DATA_W-1:0] dataCPUin,
  output logic [DATA_W-1:0] dataCPUout,
  output logic              stallCPU,
  output logic              doneCPU,
  output logic [ADR_W-1:0]  adrMM,
  output logic [DATA_W-1:0] dataMMout,
  input  logic [DATA_W-1:0] dataMMin,
  output logic              readMem,
  output logic              writeMem,
  input  logic              readyMem
);

  localparam int TAG_W = ADR_W - SET_BITS - OFF_BITS;
  localparam int SETS  = 1 << SET_BITS;
  localparam int WORDS = 1 << OFF_BITS;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, UPDATE} state_t;

  state_t              state_q;
  logic [ADR_W-1:0]    req_adr_q;
  logic [DATA_W-1:0]   req_data_q;
  logic                req_wr_q;
  logic [WAY_W-1:0]    way_q;
  logic [OFF_BITS-1:0] cnt_q;

  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic              valid_q [SETS][WAYS];
  logic              dirty_q [SETS][WAYS];
  logic [DATA_W-1:0] data_q  [SETS][WAYS][WORDS];

  logic [TAG_W-1:0]    req_tag;
  logic [SET_BITS-1:0] req_set;
  logic [OFF_BITS-1:0] req_off;
  assign {req_tag, req_set, req_off} = req_adr_q;

  assign stallCPU = (state_q != IDLE);

  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] vic_way;
  logic [WAY_W-1:0] lru_way;

  // Descending scan so the lowest-index invalid way is the last one to win.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    vic_way = lru_way;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[req_set][w] && (tag_q[req_set][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[req_set][w]) vic_way = WAY_W'(w);
    end
  end

  logic             touch;
  logic [WAY_W-1:0] touch_way;
  assign touch     = ((state_q == LOOKUP) && hit) || (state_q == UPDATE);
  assign touch_way = (state_q == UPDATE) ? way_q : hit_way;

  generate
    if (WAYS > 1) begin : g_age
      logic [WAY_W-1:0] age_q [SETS][WAYS];

      always_ff @(posedge CLK) begin
        if (RST) begin
          for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) age_q[s][w] <= WAY_W'(w);
        end else if (touch) begin
          for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == touch_way)
              age_q[req_set][w] <= '0;
            else if (age_q[req_set][w] < age_q[req_set][touch_way])
              age_q[req_set][w] <= age_q[req_set][w] + 1'b1;
          end
        end
      end

      always_comb begin
        lru_way = '0;
        for (int w = 0; w < WAYS; w++)
          if (age_q[req_set][w] == WAY_W'(WAYS - 1)) lru_way = WAY_W'(w);
      end
    end else begin : g_no_age
      assign lru_way = '0;
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      readMem    <= 1'b0;
      writeMem   <= 1'b0;
      doneCPU    <= 1'b0;
      adrMM      <= '0;
      dataMMout  <= '0;
      dataCPUout <= '0;
      req_adr_q  <= '0;
      req_data_q <= '0;
      req_wr_q   <= 1'b0;
      way_q      <= '0;
      cnt_q      <= '0;
      // NOTE: only the valid/dirty bits need a reset; tag and data arrays are
      // don't-care while invalid, so they stay plain RAM without a reset path.
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
        end
      end
    end else begin
      doneCPU <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (readCPU || writeCPU) begin
            req_adr_q  <= adrCPU;
            req_data_q <= dataCPUin;
            req_wr_q   <= !readCPU;
            state_q    <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            if (req_wr_q) begin
              data_q[req_set][hit_way][req_off] <= req_data_q;
              dirty_q[req_set][hit_way]         <= 1'b1;
            end else begin
              dataCPUout <= data_q[req_set][hit_way][req_off];
            end
            doneCPU <= 1'b1;
            state_q <= IDLE;
          end else begin
            way_q                     <= vic_way;
            cnt_q                     <= '0;
            valid_q[req_set][vic_way] <= 1'b0;
            state_q <= (valid_q[req_set][vic_way] && dirty_q[req_set][vic_way])
                       ? WRITEBACK : REFILL;
          end
        end
        WRITEBACK: begin
          if (!writeMem) begin
            writeMem  <= 1'b1;
            adrMM     <= {tag_q[req_set][way_q], req_set, cnt_q};
            dataMMout <= data_q[req_set][way_q][cnt_q];
          end else if (readyMem) begin
            writeMem <= 1'b0;
            cnt_q    <= cnt_q + 1'b1;
            if (cnt_q == OFF_BITS'(WORDS - 1)) state_q <= REFILL;
          end
        end
        REFILL: begin
          if (!readMem) begin
            readMem <= 1'b1;
            adrMM   <= {req_tag, req_set, cnt_q};
          end else if (readyMem) begin
            readMem                       <= 1'b0;
            data_q[req_set][way_q][cnt_q] <= dataMMin;
            cnt_q                         <= cnt_q + 1'b1;
            if (cnt_q == OFF_BITS'(WORDS - 1)) state_q <= UPDATE;
          end
        end
        UPDATE: begin
          tag_q[req_set][way_q]   <= req_tag;
          valid_q[req_set][way_q] <= 1'b1;
          dirty_q[req_set][way_q] <= req_wr_q;
          if (req_wr_q) data_q[req_set][way_q][req_off] <= req_data_q;
          else          dataCPUout <= data_q[req_set][way_q][req_off];
          doneCPU <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// Directed bench for set_assoc_cache_ctrl: CPU transactions against a behavioural
// main memory with configurable readyMem latency and a transaction log.
module tb_set_assoc_cache_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        readCPU, writeCPU;
  logic [15:0] adrCPU;
  logic [7:0]  dataCPUin, dataCPUout;
  logic        stallCPU, doneCPU;
  logic [15:0] adrMM;
  logic [7:0]  dataMMout, dataMMin;
  logic        readMem, writeMem, readyMem;

  set_assoc_cache_ctrl dut (
    .CLK(CLK), .RST(RST), .readCPU(readCPU), .writeCPU(writeCPU), .adrCPU(adrCPU),
    .dataCPUin(dataCPUin), .dataCPUout(dataCPUout), .stallCPU(stallCPU), .doneCPU(doneCPU),
    .adrMM(adrMM), .dataMMout(dataMMout), .dataMMin(dataMMin),
    .readMem(readMem), .writeMem(writeMem), .readyMem(readyMem)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        we;
    logic [15:0] adr;
    logic [7:0]  dat;
  } txn_t;

  txn_t       txn_q[$];
  logic [7:0] mem [65536];
  int         mem_lat    = 0;
  int         wait_cnt   = 0;
  int         stab_err   = 0;
  int         stall_low  = 0;
  int         wait_total = 0;
  logic [15:0] first_adr;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ 8'h3C;
  endfunction

  // Memory responder: one readyMem pulse per request after mem_lat waiting cycles.
  initial begin
    readyMem = 1'b0;
    dataMMin = '0;
    forever begin
      @(negedge CLK);
      if (readyMem) begin
        readyMem = 1'b0;
      end else if (readMem || writeMem) begin
        if (readMem && writeMem) stab_err++;
        if (wait_cnt == 0) first_adr = adrMM;
        else if (adrMM !== first_adr) stab_err++;
        if (!stallCPU) stall_low++;
        wait_total++;
        if (wait_cnt >= mem_lat) begin
          if (writeMem) begin
            mem[adrMM] = dataMMout;
            txn_q.push_back('{we: 1'b1, adr: adrMM, dat: dataMMout});
          end else begin
            dataMMin = mem[adrMM];
            txn_q.push_back('{we: 1'b0, adr: adrMM, dat: mem[adrMM]});
          end
          readyMem = 1'b1;
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic check_txn(input string tag, input int idx, input logic we,
                           input logic [15:0] adr, input logic [7:0] dat);
    if (idx < txn_q.size()) begin
      check({tag, "_we"}, txn_q[idx].we, we);
      check({tag, "_adr"}, txn_q[idx].adr, adr);
      check({tag, "_dat"}, txn_q[idx].dat, dat);
    end else begin
      check({tag, "_missing"}, txn_q.size(), idx + 1);
    end
  endtask

  task automatic cpu_op(input logic rd, input logic wr, input logic [15:0] adr,
                        input logic [7:0] din, output logic [7:0] dout, output int lat);
    txn_q.delete();
    @(negedge CLK);
    readCPU = rd; writeCPU = wr; adrCPU = adr; dataCPUin = din;
    @(negedge CLK);
    readCPU = 1'b0; writeCPU = 1'b0;
    check("stall_busy", stallCPU, 1);
    lat = 1;
    while (!doneCPU && lat < 400) begin
      @(negedge CLK);
      lat++;
    end
    check("done_seen", doneCPU, 1);
    dout = dataCPUout;
    @(negedge CLK);
    check("done_pulse", doneCPU, 0);
  endtask

  logic [7:0] dout;
  int         lat;
  int         cyc;
  logic [7:0] wb_exp [4] = '{8'hA0, 8'h5C, 8'hA2, 8'hA3};
  logic [15:0] fill_adr [3] = '{16'h0014, 16'h0034, 16'h0054};

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = init_val(16'(i));
    for (int k = 0; k < 4; k++) mem[16'h1234 + k] = 8'hA0 + 8'(k);
    RST = 1'b1; readCPU = 1'b0; writeCPU = 1'b0; adrCPU = '0; dataCPUin = '0;
    repeat (3) @(negedge CLK);
    check("rst_readMem", readMem, 0);
    check("rst_writeMem", writeMem, 0);
    check("rst_stall", stallCPU, 0);
    check("rst_done", doneCPU, 0);
    check("rst_adrMM", adrMM, 0);
    check("rst_dataMMout", dataMMout, 0);
    check("rst_dataCPUout", dataCPUout, 0);
    RST = 1'b0;

    // Cold read miss, clean refill
    cpu_op(1, 0, 16'h1234, 8'h00, dout, lat);
    check("r31_data", dout, 8'hA0);
    check("r31_ntxn", txn_q.size(), 4);
    for (int k = 0; k < 4; k++) check_txn("r31", k, 0, 16'h1234 + 16'(k), 8'hA0 + 8'(k));

    // Read hit
    cpu_op(1, 0, 16'h1236, 8'h00, dout, lat);
    check("r32_data", dout, 8'hA2);
    check("r32_lat", lat, 2);
    check("r32_ntxn", txn_q.size(), 0);

    // Write hit then read back
    cpu_op(0, 1, 16'h1235, 8'h5C, dout, lat);
    check("w33_lat", lat, 2);
    check("w33_ntxn", txn_q.size(), 0);
    cpu_op(1, 0, 16'h1235, 8'h00, dout, lat);
    check("r33_data", dout, 8'h5C);
    check("r33_lat", lat, 2);
    check("r33_ntxn", txn_q.size(), 0);

    // Fill the set, then evict the dirty LRU line
    for (int j = 0; j < 3; j++) begin
      cpu_op(1, 0, fill_adr[j], 8'h00, dout, lat);
      check("r34_fill_data", dout, init_val(fill_adr[j]));
      check("r34_fill_ntxn", txn_q.size(), 4);
    end
    cpu_op(1, 0, 16'h0074, 8'h00, dout, lat);
    check("r34_data", dout, 8'h48);
    check("r34_ntxn", txn_q.size(), 8);
    for (int k = 0; k < 4; k++) check_txn("r34_wb", k, 1, 16'h1234 + 16'(k), wb_exp[k]);
    for (int k = 0; k < 4; k++)
      check_txn("r34_rf", 4 + k, 0, 16'h0074 + 16'(k), init_val(16'h0074 + 16'(k)));

    // Slow memory; read and write requested together
    mem_lat = 20; stab_err = 0; stall_low = 0; wait_total = 0;
    cpu_op(1, 1, 16'h1235, 8'hEE, dout, lat);
    check("r35_data", dout, 8'h5C);
    check("r35_ntxn", txn_q.size(), 4);
    check("r35_stable", stab_err, 0);
    check("r35_stall", stall_low, 0);
    check("r35_wait", wait_total, 84);
    for (int k = 0; k < 4; k++) check_txn("r35", k, 0, 16'h1234 + 16'(k), wb_exp[k]);
    mem_lat = 0;
    cpu_op(1, 0, 16'h1235, 8'h00, dout, lat);
    check("r35_hit_data", dout, 8'h5C);
    check("r35_hit_lat", lat, 2);
    check("r35_hit_ntxn", txn_q.size(), 0);

    // Reset while the third refill word is outstanding
    mem_lat = 5;
    txn_q.delete();
    @(negedge CLK);
    readCPU = 1'b1; adrCPU = 16'h0094;
    @(negedge CLK);
    readCPU = 1'b0;
    cyc = 0;
    while (!(readMem && !readyMem && txn_q.size() == 2) && cyc < 300) begin
      @(negedge CLK);
      cyc++;
    end
    check("r36_reach_ntxn", txn_q.size(), 2);
    check("r36_reach_readMem", readMem, 1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("r36_readMem", readMem, 0);
    check("r36_writeMem", writeMem, 0);
    check("r36_stall", stallCPU, 0);
    mem_lat = 0;
    cpu_op(1, 0, 16'h1234, 8'h00, dout, lat);
    check("r36_data", dout, 8'hA0);
    check("r36_ntxn", txn_q.size(), 4);
    check_txn("r36", 0, 0, 16'h1234, 8'hA0);

    // Write miss allocates without writing memory
    cpu_op(0, 1, 16'h2000, 8'h77, dout, lat);
    check("wm_ntxn", txn_q.size(), 4);
    for (int k = 0; k < 4; k++) check_txn("wm", k, 0, 16'h2000 + 16'(k), init_val(16'h2000 + 16'(k)));
    cpu_op(1, 0, 16'h2000, 8'h00, dout, lat);
    check("wm_rd0_data", dout, 8'h77);
    check("wm_rd0_lat", lat, 2);
    cpu_op(1, 0, 16'h2001, 8'h00, dout, lat);
    check("wm_rd1_data", dout, 8'h3D);
    check("wm_rd1_ntxn", txn_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
